// File: rtl/lmsm_pkg.sv
// Shared types and constants for the LM/SM register-list sequencer.
// Holds the FSM state encoding and the lowest-set-bit clear helper.
package lmsm_pkg;

  localparam int LIST_W = 8;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Drop the lowest set bit: x & (x - 1).
  function automatic logic [LIST_W-1:0] clear_lowest(input logic [LIST_W-1:0] mask);
    return mask & (mask - {{(LIST_W-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/lmsm_sequencer_prio_enc8.sv
// Combinational lowest-set-bit encoder for an 8-bit register list.
// multi flags that at least one more bit remains after the lowest one.
module prio_enc8
  import lmsm_pkg::*;
(
  input  logic [LIST_W-1:0] mask,
  output logic [IDX_W-1:0]  idx,
  output logic              any,
  output logic              multi
);

  // Lowest set bit wins; an empty mask encodes as index 0.
  always_comb begin
    idx = 3'd0;
    casez (mask)
      8'b???????1: idx = 3'd0;
      8'b??????10: idx = 3'd1;
      8'b?????100: idx = 3'd2;
      8'b????1000: idx = 3'd3;
      8'b???10000: idx = 3'd4;
      8'b??100000: idx = 3'd5;
      8'b?1000000: idx = 3'd6;
      8'b10000000: idx = 3'd7;
      default:     idx = 3'd0;
    endcase
  end

  assign any   = |mask;
  assign multi = |clear_lowest(mask);

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM register-list walker: one register index and address per enabled cycle.
// The first transfer comes straight from reg_list/base_addr, so there is no start-up bubble.
module lmsm_sequencer
  import lmsm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              hold,
  input  logic [LIST_W-1:0] reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              xfer_valid,
  output logic [IDX_W-1:0]  reg_idx,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic              vbit,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [LIST_W-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [LIST_W-1:0] cur_mask_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [IDX_W-1:0]  enc_idx_s;
  logic              enc_any_s;
  logic              enc_multi_s;
  logic              advance_s;
  logic              vbit_s;

  // In IDLE the instruction's own list is walked directly; in RUN the remaining bits are.
  assign cur_mask_s = (state_q == RUN) ? mask_q : reg_list;
  assign cur_addr_s = (state_q == RUN) ? addr_q : base_addr;
  assign advance_s  = en & ~hold;
  assign vbit_s     = en & enc_multi_s;

  prio_enc8 u_enc (
    .mask  (cur_mask_s),
    .idx   (enc_idx_s),
    .any   (enc_any_s),
    .multi (enc_multi_s)
  );

  // State register and walk registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= 8'h00;
      addr_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic: advance on en & ~hold, abort to IDLE when the instruction is flushed.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (advance_s) begin
          mask_d  = clear_lowest(cur_mask_s);
          addr_d  = cur_addr_s + 16'd1;
          state_d = vbit_s ? RUN : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          mask_d  = 8'h00;
          state_d = IDLE;
        end else if (!hold) begin
          mask_d  = clear_lowest(cur_mask_s);
          addr_d  = cur_addr_s + 16'd1;
          state_d = vbit_s ? RUN : IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        mask_d  = 8'h00;
        state_d = IDLE;
      end
    endcase
  end

  // Output drive; everything is held at zero while reset is asserted.
  always_comb begin
    if (reset) begin
      xfer_valid = 1'b0;
      reg_idx    = 3'd0;
      xfer_addr  = 16'h0000;
      vbit       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
    end else begin
      xfer_valid = en & enc_any_s;
      reg_idx    = enc_idx_s;
      xfer_addr  = cur_addr_s;
      vbit       = vbit_s;
      busy       = (state_q == RUN);
      done       = advance_s & ~vbit_s;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: a vector table of per-cycle stimulus and
// expected outputs, plus hand-written hold, abort and reset sequences.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        reset, en, hold;
  logic [7:0]  reg_list;
  logic [15:0] base_addr;
  logic        xfer_valid, vbit, busy, done;
  logic [2:0]  reg_idx;
  logic [15:0] xfer_addr;

  int tests_run = 0;
  int tests_failed = 0;
  int done_seen = 0;

  typedef struct {
    logic        rst;
    logic        en;
    logic        hold;
    logic [7:0]  list;
    logic [15:0] base;
    logic        vld;
    logic [2:0]  idx;
    logic [15:0] addr;
    logic        vb;
    logic        bsy;
    logic        dn;
    string       name;
  } vec_t;

  vec_t vecs[$];

  lmsm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .hold       (hold),
    .reg_list   (reg_list),
    .base_addr  (base_addr),
    .xfer_valid (xfer_valid),
    .reg_idx    (reg_idx),
    .xfer_addr  (xfer_addr),
    .vbit       (vbit),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic h, input logic [7:0] l,
                     input logic [15:0] b, input logic v, input logic [2:0] i,
                     input logic [15:0] a, input logic vb, input logic bs, input logic d,
                     input string n);
    vec_t t;
    t.rst = r; t.en = e; t.hold = h; t.list = l; t.base = b;
    t.vld = v; t.idx = i; t.addr = a; t.vb = vb; t.bsy = bs; t.dn = d; t.name = n;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs after the falling edge, then check the combinational outputs.
  task automatic step(input vec_t t);
    logic [22:0] act, exp;
    @(negedge clk);
    reset = t.rst; en = t.en; hold = t.hold; reg_list = t.list; base_addr = t.base;
    #1;
    act = {xfer_valid, reg_idx, xfer_addr, vbit, busy, done};
    exp = {t.vld, t.idx, t.addr, t.vb, t.bsy, t.dn};
    if (done) done_seen++;
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got vld=%b idx=%0d addr=%h vbit=%b busy=%b done=%b, want vld=%b idx=%0d addr=%h vbit=%b busy=%b done=%b",
               t.name, xfer_valid, reg_idx, xfer_addr, vbit, busy, done,
               t.vld, t.idx, t.addr, t.vb, t.bsy, t.dn);
    end
  endtask

  task automatic run_s(input logic r, input logic e, input logic h, input logic [7:0] l,
                       input logic [15:0] b, input logic v, input logic [2:0] i,
                       input logic [15:0] a, input logic vb, input logic bs, input logic d,
                       input string n);
    vec_t t;
    t.rst = r; t.en = e; t.hold = h; t.list = l; t.base = b;
    t.vld = v; t.idx = i; t.addr = a; t.vb = vb; t.bsy = bs; t.dn = d; t.name = n;
    step(t);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; hold = 1'b0; reg_list = 8'h00; base_addr = 16'h0000;

    //   rst  en   hold list   base      vld  idx   addr      vbit bsy  done
    add(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "reset");
    add(1'b0, 1'b1, 1'b0, 8'hA5, 16'h0040, 1'b1, 3'd0, 16'h0040, 1'b1, 1'b0, 1'b0, "multi_0");
    add(1'b0, 1'b1, 1'b0, 8'hA5, 16'h0040, 1'b1, 3'd2, 16'h0041, 1'b1, 1'b1, 1'b0, "multi_1");
    add(1'b0, 1'b1, 1'b0, 8'hA5, 16'h0040, 1'b1, 3'd5, 16'h0042, 1'b1, 1'b1, 1'b0, "multi_2");
    add(1'b0, 1'b1, 1'b0, 8'hA5, 16'h0040, 1'b1, 3'd7, 16'h0043, 1'b0, 1'b1, 1'b1, "multi_3");
    add(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "multi_idle");
    add(1'b0, 1'b1, 1'b0, 8'h00, 16'h1000, 1'b0, 3'd0, 16'h1000, 1'b0, 1'b0, 1'b1, "empty");
    add(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "empty_idle");
    add(1'b0, 1'b1, 1'b0, 8'h40, 16'hFFFF, 1'b1, 3'd6, 16'hFFFF, 1'b0, 1'b0, 1'b1, "single_top");
    add(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "single_idle");
    // Inputs change during RUN to show they are ignored after the first cycle.
    add(1'b0, 1'b1, 1'b0, 8'h0F, 16'hFFFE, 1'b1, 3'd0, 16'hFFFE, 1'b1, 1'b0, 1'b0, "wrap_0");
    add(1'b0, 1'b1, 1'b0, 8'h80, 16'h5555, 1'b1, 3'd1, 16'hFFFF, 1'b1, 1'b1, 1'b0, "wrap_1");
    add(1'b0, 1'b1, 1'b0, 8'h80, 16'h5555, 1'b1, 3'd2, 16'h0000, 1'b1, 1'b1, 1'b0, "wrap_2");
    add(1'b0, 1'b1, 1'b0, 8'h80, 16'h5555, 1'b1, 3'd3, 16'h0001, 1'b0, 1'b1, 1'b1, "wrap_3");
    add(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "wrap_idle");
    add(1'b0, 1'b1, 1'b1, 8'h03, 16'h0300, 1'b1, 3'd0, 16'h0300, 1'b1, 1'b0, 1'b0, "idle_hold_0");
    add(1'b0, 1'b1, 1'b1, 8'h03, 16'h0300, 1'b1, 3'd0, 16'h0300, 1'b1, 1'b0, 1'b0, "idle_hold_1");
    add(1'b0, 1'b1, 1'b0, 8'h03, 16'h0300, 1'b1, 3'd0, 16'h0300, 1'b1, 1'b0, 1'b0, "idle_hold_go");
    add(1'b0, 1'b1, 1'b0, 8'h03, 16'h0300, 1'b1, 3'd1, 16'h0301, 1'b0, 1'b1, 1'b1, "idle_hold_last");
    add(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "idle_hold_end");

    for (int k = 0; k < vecs.size(); k++) step(vecs[k]);

    // Hold on the second transfer for two cycles.
    done_seen = 0;
    run_s(1'b0, 1'b1, 1'b0, 8'h07, 16'h0200, 1'b1, 3'd0, 16'h0200, 1'b1, 1'b0, 1'b0, "hold_t0");
    run_s(1'b0, 1'b1, 1'b1, 8'h07, 16'h0200, 1'b1, 3'd1, 16'h0201, 1'b1, 1'b1, 1'b0, "hold_t1a");
    run_s(1'b0, 1'b1, 1'b1, 8'h07, 16'h0200, 1'b1, 3'd1, 16'h0201, 1'b1, 1'b1, 1'b0, "hold_t1b");
    run_s(1'b0, 1'b1, 1'b0, 8'h07, 16'h0200, 1'b1, 3'd1, 16'h0201, 1'b1, 1'b1, 1'b0, "hold_t1c");
    run_s(1'b0, 1'b1, 1'b0, 8'h07, 16'h0200, 1'b1, 3'd2, 16'h0202, 1'b0, 1'b1, 1'b1, "hold_t2");
    run_s(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "hold_end");
    tests_run++;
    if (done_seen != 1) begin
      tests_failed++;
      $display("FAIL hold_done_count: got %0d done pulses, want 1", done_seen);
    end

    // Flush mid-run: drop en after two transfers.
    run_s(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0010, 1'b1, 3'd0, 16'h0010, 1'b1, 1'b0, 1'b0, "abort_t0");
    run_s(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0010, 1'b1, 3'd1, 16'h0011, 1'b1, 1'b1, 1'b0, "abort_t1");
    run_s(1'b0, 1'b0, 1'b0, 8'hFF, 16'h0010, 1'b0, 3'd2, 16'h0012, 1'b0, 1'b1, 1'b0, "abort_drop");
    run_s(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "abort_idle");
    run_s(1'b0, 1'b1, 1'b0, 8'h01, 16'h0020, 1'b1, 3'd0, 16'h0020, 1'b0, 1'b0, 1'b1, "abort_next");

    // Reset mid-run.
    run_s(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0010, 1'b1, 3'd0, 16'h0010, 1'b1, 1'b0, 1'b0, "rst_t0");
    run_s(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0010, 1'b1, 3'd1, 16'h0011, 1'b1, 1'b1, 1'b0, "rst_t1");
    run_s(1'b1, 1'b1, 1'b0, 8'hFF, 16'h0010, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "rst_assert");
    run_s(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, "rst_idle");
    run_s(1'b0, 1'b1, 1'b0, 8'h02, 16'h0030, 1'b1, 3'd1, 16'h0030, 1'b0, 1'b0, 1'b1, "rst_next");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
